// File: rtl/game_move_controller.sv
// Move sequencer for a drop-token board game: scans the requested column bottom-up
// through an external board port, writes the mover's token, and enforces turn timeouts.
module game_move_controller #(
    parameter int ROWS           = 6,
    parameter int COLS           = 7,
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p1_req,
    input  logic       p2_req,
    input  logic [2:0] p1_col,
    input  logic [2:0] p2_col,
    input  logic       restart,
    output logic [2:0] rd_row,
    output logic [2:0] rd_col,
    input  logic [1:0] rd_data,
    output logic       wr_en,
    output logic [2:0] wr_row,
    output logic [2:0] wr_col,
    output logic [1:0] wr_data,
    output logic       turn,
    output logic       move_done,
    output logic       move_err,
    output logic       turn_timeout,
    output logic       busy,
    output logic       board_full
);

    localparam int              TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0]   TLAST   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [5:0]      CELLS   = 6'(ROWS * COLS);
    localparam logic [2:0]      TOP_ROW = 3'(ROWS - 1);
    localparam logic [3:0]      NCOLS   = 4'(COLS);

    typedef enum logic [1:0] {IDLE, SCAN, WRITE, ERR} state_t;

    state_t        state_q, state_d;
    logic [2:0]    row_q, row_d;
    logic [2:0]    col_q, col_d;
    logic [5:0]    moves_q, moves_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          turn_q, turn_d;
    logic          req_sel;
    logic [2:0]    col_sel;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            moves_q <= '0;
            timer_q <= '0;
            turn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            moves_q <= moves_d;
            timer_q <= timer_d;
            turn_q  <= turn_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        moves_d      = moves_q;
        timer_d      = '0;
        turn_d       = turn_q;
        rd_row       = '0;
        rd_col       = '0;
        wr_en        = 1'b0;
        wr_row       = '0;
        wr_col       = '0;
        wr_data      = '0;
        move_done    = 1'b0;
        move_err     = 1'b0;
        turn_timeout = 1'b0;
        turn         = turn_q;
        busy         = (state_q != IDLE);
        board_full   = (moves_q == CELLS);
        req_sel      = turn_q ? p2_req : p1_req;
        col_sel      = turn_q ? p2_col : p1_col;

        case (state_q)
            IDLE: begin
                // Only the player on turn is heard; a live request beats a timeout.
                if (req_sel) begin
                    col_d   = col_sel;
                    row_d   = '0;
                    state_d = (({1'b0, col_sel} >= NCOLS) || board_full) ? ERR : SCAN;
                end else if (board_full) begin
                    timer_d = timer_q;
                end else if (timer_q == TLAST) begin
                    turn_timeout = 1'b1;
                    turn_d       = ~turn_q;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            SCAN: begin
                rd_row = row_q;
                rd_col = col_q;
                if (rd_data == 2'b00) begin
                    state_d = WRITE;
                end else if (row_q == TOP_ROW) begin
                    state_d = ERR;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            WRITE: begin
                wr_en     = 1'b1;
                wr_row    = row_q;
                wr_col    = col_q;
                wr_data   = turn_q ? 2'b10 : 2'b01;
                move_done = 1'b1;
                moves_d   = moves_q + 1'b1;
                turn_d    = ~turn_q;
                state_d   = IDLE;
            end
            ERR: begin
                move_err = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Restart overrides everything, including a write already in its final cycle.
        if (restart) begin
            state_d      = IDLE;
            row_d        = '0;
            col_d        = '0;
            moves_d      = '0;
            timer_d      = '0;
            turn_d       = 1'b0;
            wr_en        = 1'b0;
            wr_row       = '0;
            wr_col       = '0;
            wr_data      = '0;
            move_done    = 1'b0;
            move_err     = 1'b0;
            turn_timeout = 1'b0;
        end
    end

endmodule

// File: tb/tb_game_move_controller.sv
// Scoreboard bench for game_move_controller: a board-level reference model predicts
// each move outcome and a forked monitor matches DUT event pulses against the queue.
module tb_game_move_controller;

    localparam int ROWS = 6;
    localparam int COLS = 7;
    localparam int TMO  = 8;

    typedef struct {
        int         kind;   // 0 = move_done, 1 = move_err, 2 = turn_timeout
        int         cyc;
        logic [2:0] row;
        logic [2:0] col;
        logic [1:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       p1Req, p2Req, restart;
    logic [2:0] p1Col, p2Col;
    logic [2:0] rdRow, rdCol, wrRow, wrCol;
    logic [1:0] rdData, wrData;
    logic       wrEn, turn, moveDone, moveErr, turnTimeout, busy, boardFull;

    int   cycleCnt = 0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t expQ[$];

    logic [1:0] envBoard [8][8];
    logic       envClear;

    int refBoard [ROWS][COLS];
    int refMoves;
    bit refTurn;

    game_move_controller #(.ROWS(ROWS), .COLS(COLS), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset),
        .p1_req(p1Req), .p2_req(p2Req), .p1_col(p1Col), .p2_col(p2Col),
        .restart(restart),
        .rd_row(rdRow), .rd_col(rdCol), .rd_data(rdData),
        .wr_en(wrEn), .wr_row(wrRow), .wr_col(wrCol), .wr_data(wrData),
        .turn(turn), .move_done(moveDone), .move_err(moveErr), .turn_timeout(turnTimeout),
        .busy(busy), .board_full(boardFull)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle index: cycle k is the interval following the k-th rising edge.
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // External board memory that the controller scans and writes.
    assign rdData = envBoard[rdRow][rdCol];
    always @(posedge clk) begin
        if (envClear) begin
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    envBoard[r][c] <= 2'b00;
        end else if (wrEn) begin
            envBoard[wrRow][wrCol] <= wrData;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cycleCnt);
        end
    endtask

    function automatic logic [3:0] patternOf(input int kind);
        case (kind)
            0:       return 4'b1001;
            1:       return 4'b0100;
            default: return 4'b0010;
        endcase
    endfunction

    // Monitor: matches each observed event pulse against the oldest expectation.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            while (expQ.size() > 0 && expQ[0].cyc < cycleCnt) begin
                e = expQ.pop_front();
                compared++;
                mismatched++;
                $display("[TB] FAIL missing_event: got none expected kind %0d at cycle %0d", e.kind, e.cyc);
            end
            if (moveDone || moveErr || turnTimeout || wrEn) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_event: got pulses %b expected none (cycle %0d)",
                             {moveDone, moveErr, turnTimeout, wrEn}, cycleCnt);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("event_cycle", cycleCnt, e.cyc);
                    checkOutput("event_pulses", {moveDone, moveErr, turnTimeout, wrEn}, patternOf(e.kind));
                    if (e.kind == 0) begin
                        checkOutput("wr_row", wrRow, e.row);
                        checkOutput("wr_col", wrCol, e.col);
                        checkOutput("wr_data", wrData, e.data);
                    end
                end
            end
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic resetModel();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                refBoard[r][c] = 0;
        refMoves = 0;
        refTurn  = 1'b0;
    endtask

    // Game rules: bad column or full board fails at once; otherwise the token lands on the
    // lowest empty row after scanning rows 0..r, or fails after scanning a full column.
    function automatic void predict(input logic [2:0] col, output int kind, output int lat, output int row);
        int c;
        c    = int'(col);
        kind = 1;
        lat  = 1;
        row  = 0;
        if (c >= COLS || refMoves == ROWS * COLS) return;
        lat = ROWS + 1;
        for (int r = 0; r < ROWS; r++) begin
            if (refBoard[r][c] == 0) begin
                kind = 0;
                lat  = 2 + r;
                row  = r;
                return;
            end
        end
    endfunction

    task automatic checkResetState();
        checkOutput("reset_outputs",
                    {wrEn, wrRow, wrCol, wrData, rdRow, rdCol, moveDone, moveErr, turnTimeout}, 0);
        checkOutput("reset_turn", turn, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_board_full", boardFull, 0);
    endtask

    // Issues one request from the player on turn, queues its predicted outcome and waits it out.
    task automatic applyStimulus(input logic [2:0] col, input bit otherToo, input bit busyNoise);
        int   kind, lat, row, n;
        exp_t e;
        checkOutput("turn_at_issue", turn, refTurn);
        checkOutput("board_full_at_issue", boardFull, refMoves == ROWS * COLS);
        n = cycleCnt;
        predict(col, kind, lat, row);
        e.kind = kind;
        e.cyc  = n + lat;
        e.row  = 3'(row);
        e.col  = col;
        e.data = refTurn ? 2'b10 : 2'b01;
        expQ.push_back(e);
        if (!refTurn) begin
            p1Req = 1'b1; p1Col = col;
            if (otherToo) begin p2Req = 1'b1; p2Col = 3'($urandom_range(0, 7)); end
        end else begin
            p2Req = 1'b1; p2Col = col;
            if (otherToo) begin p1Req = 1'b1; p1Col = 3'($urandom_range(0, 7)); end
        end
        nextCycle();
        p1Req = 1'b0; p2Req = 1'b0;
        for (int i = 1; i <= lat; i++) begin
            if (busyNoise && $urandom_range(0, 1) == 1) begin
                p1Req = 1'b1; p1Col = 3'($urandom_range(0, 7));
                p2Req = 1'b1; p2Col = 3'($urandom_range(0, 7));
            end
            nextCycle();
            p1Req = 1'b0; p2Req = 1'b0;
        end
        if (kind == 0) begin
            refBoard[row][int'(col)] = refTurn ? 2 : 1;
            refMoves++;
            refTurn = ~refTurn;
        end
    endtask

    // Idle cycles in which only the player not on turn may be pressing.
    task automatic idleGap(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                if (refTurn) begin p1Req = 1'b1; p1Col = 3'($urandom_range(0, 7)); end
                else         begin p2Req = 1'b1; p2Col = 3'($urandom_range(0, 7)); end
            end
            nextCycle();
            p1Req = 1'b0; p2Req = 1'b0;
        end
    endtask

    // Starts a move, then kills it during its first scan cycle by restart or reset.
    task automatic abortMove(input logic [2:0] col, input bit useReset);
        if (!refTurn) begin p1Req = 1'b1; p1Col = col; end
        else          begin p2Req = 1'b1; p2Col = col; end
        nextCycle();
        p1Req = 1'b0; p2Req = 1'b0;
        if (useReset) reset = 1'b0;
        else          restart = 1'b1;
        envClear = 1'b1;
        nextCycle();
        restart  = 1'b0;
        envClear = 1'b0;
        if (useReset) begin
            checkResetState();
            reset = 1'b1;
        end
        resetModel();
        checkOutput("abort_turn", turn, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_board_full", boardFull, 0);
    endtask

    // Main sequence: directed scenarios, a random game to a full board, then final reset.
    initial begin
        exp_t e;
        int   s;
        reset = 1'b0; restart = 1'b0; envClear = 1'b1;
        p1Req = 1'b0; p2Req = 1'b0; p1Col = '0; p2Col = '0;
        resetModel();
        fork
            monitor();
        join_none
        repeat (3) nextCycle();
        checkResetState();
        envClear = 1'b0;
        reset = 1'b1;

        applyStimulus(3'd3, 0, 0);
        checkOutput("turn_after_first_move", turn, 1);

        applyStimulus(3'd2, 0, 0);
        applyStimulus(3'd2, 0, 0);
        applyStimulus(3'd2, 0, 0);
        applyStimulus(3'd5, 0, 0);
        applyStimulus(3'd2, 0, 0);

        applyStimulus(3'd7, 0, 0);

        for (int i = 0; i < ROWS; i++) applyStimulus(3'd4, 0, 0);
        applyStimulus(3'd4, 0, 1);

        p2Req = 1'b1; p2Col = 3'd1;
        nextCycle();
        p2Req = 1'b0;
        checkOutput("wrong_player_busy", busy, 0);
        checkOutput("wrong_player_turn", turn, 0);

        applyStimulus(3'd0, 1, 1);

        s = cycleCnt;
        e.kind = 2; e.row = '0; e.col = '0; e.data = '0;
        e.cyc = s + TMO - 1;     expQ.push_back(e);
        e.cyc = s + 2 * TMO - 1; expQ.push_back(e);
        repeat (TMO) nextCycle();
        refTurn = ~refTurn;
        checkOutput("turn_after_timeout1", turn, refTurn);
        repeat (TMO) nextCycle();
        refTurn = ~refTurn;
        checkOutput("turn_after_timeout2", turn, refTurn);
        repeat (TMO - 1) nextCycle();
        applyStimulus(3'd6, 0, 0);

        abortMove(3'd6, 0);
        abortMove(3'd1, 1);

        for (int i = 0; i < 800 && refMoves < ROWS * COLS; i++) begin
            idleGap($urandom_range(0, 4));
            applyStimulus(3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end
        checkOutput("board_full_level", boardFull, 1);
        repeat (3 * TMO) nextCycle();
        applyStimulus(3'($urandom_range(0, COLS - 1)), 0, 0);
        checkOutput("full_turn_kept", turn, refTurn);

        reset = 1'b0;
        nextCycle();
        checkResetState();
        reset = 1'b1;
        resetModel();
        envClear = 1'b1;
        nextCycle();
        envClear = 1'b0;

        for (int i = 0; i < 20 && expQ.size() > 0; i++) nextCycle();
        repeat (2) nextCycle();
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            compared++;
            mismatched++;
            $display("[TB] FAIL never_seen: got none expected kind %0d at cycle %0d", e.kind, e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/game_move_controller.md
GAME_MOVE_CONTROLLER -- requirements
Module: game_move_controller

Interface
REQ-001 The block SHALL have parameter ROWS, default 6, meaning board rows (row 0 = bottom).
REQ-002 The block SHALL have parameter COLS, default 7, meaning board columns.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 50_000_000, meaning idle cycles before a turn is forfeited.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have ports p1_req / p2_req, input, 1 bit each: drop request from player 1 / player 2.
REQ-007 The block SHALL have ports p1_col / p2_col, input, 3 bits each: requested column.
REQ-008 The block SHALL have port restart, input, 1 bit: synchronous game restart.
REQ-009 The block SHALL have ports rd_row (3 bits) and rd_col (3 bits), output: board read address.
REQ-010 The block SHALL have port rd_data, input, 2 bits: cell contents at rd_row/rd_col, combinational, same cycle.
REQ-011 The block SHALL have ports wr_en (1 bit), wr_row (3 bits), wr_col (3 bits), wr_data (2 bits), output: board write port.
REQ-012 The block SHALL have port turn, output, 1 bit: 0 = player 1 (token 2'b01), 1 = player 2 (token 2'b10).
REQ-013 The block SHALL have ports move_done, move_err and turn_timeout, output, 1 bit each: single-cycle event pulses.
REQ-014 The block SHALL have ports busy and board_full, output, 1 bit each: status levels.

Function
REQ-015 The FSM SHALL have states IDLE, SCAN, WRITE and ERR.
REQ-016 In IDLE, only the request of the player indicated by turn SHALL be sampled; the other player's request SHALL be ignored without any pulse, including when both requests are high in the same cycle.
REQ-017 On an accepted request in cycle N, the column SHALL be latched and the FSM SHALL enter SCAN with the scan row set to 0.
REQ-018 An accepted request with column >= COLS, or while board_full=1, SHALL go to ERR instead of SCAN.
REQ-019 In SCAN, rd_row SHALL equal the scan row and rd_col SHALL equal the latched column.
REQ-020 In SCAN, rd_data == 2'b00 SHALL move the FSM to WRITE with that row latched; otherwise the scan row SHALL increment.
REQ-021 In SCAN, an occupied cell at row ROWS-1 (column full) SHALL move the FSM to ERR.
REQ-022 WRITE SHALL last exactly one cycle and assert wr_en, wr_row, wr_col, wr_data = turn token, and move_done.
REQ-023 In the WRITE cycle, the move counter (6 bits) SHALL increment and turn SHALL toggle; the FSM SHALL then return to IDLE.
REQ-024 Latency SHALL be as follows: the first empty cell at row r gives wr_en/move_done in cycle N+2+r.
REQ-025 ERR SHALL last one cycle, assert move_err, leave turn and the counter unchanged, and return to IDLE.
REQ-026 busy SHALL be 1 in every state except IDLE; requests arriving while busy SHALL be dropped.
REQ-027 board_full SHALL equal (move counter == ROWS*COLS).
REQ-028 The timeout counter SHALL count only in IDLE while board_full=0, and SHALL clear on acceptance, on leaving IDLE and on restart.
REQ-029 When the timeout counter reaches TIMEOUT_CYCLES-1 in IDLE, the block SHALL pulse turn_timeout, toggle turn and clear the counter.
REQ-030 If a request is accepted in the same cycle as the timeout, the request SHALL win and no timeout SHALL fire.
REQ-031 restart SHALL force IDLE, turn=0, move counter=0 and timer=0 on the next edge, abort any move (no wr_en), and take priority over all events.
REQ-032 wr_en SHALL be 0 in every state except WRITE, and rd_row/rd_col SHALL be 0 when not in SCAN.

Reset
REQ-033 While reset=0, the state SHALL be IDLE and all of the following SHALL be 0: turn, move counter, timer, wr_en, wr_row, wr_col, wr_data, rd_row, rd_col, move_done, move_err, turn_timeout, busy and board_full.
REQ-034 Reset assertion mid-move SHALL abort the move immediately with no write.
REQ-035 Reset deassertion SHALL take effect at the next clock edge.

Verification
REQ-036 Empty board, p1_req col 3 in cycle N -> wr_en in N+2 with row 0, col 3, data 01; move_done=1; turn=1.
REQ-037 Column 2 holds rows 0-2, p2's turn, p2 col 2 -> wr_en in N+5 with row 3, data 10; turn=0.
REQ-038 Column 4 full, p1 col 4 -> move_err in N+7, no wr_en, turn stays 0; p1 col 7 -> move_err in N+1.
REQ-039 turn=0, p1_req and p2_req high together -> only p1 is accepted; a p2_req alone on turn 0 -> no pulse and no state change.
REQ-040 TIMEOUT_CYCLES=8, no requests -> turn_timeout after 8 IDLE cycles, turn toggles; restart during SCAN -> no write, turn=0.
REQ-041 42 legal moves -> board_full=1, timer frozen; a further request -> move_err; reset -> board_full=0.
